// File: rtl/datapath.sv
// Multicycle MIPS-style datapath.
// Holds the architectural state (PC, IR, 32x32 register file) and the
// per-cycle holding registers (data, A, B, aluout) that split each
// instruction into fetch/decode/execute/writeback cycles under an external
// controller.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; wins over every write strobe
//   pcen        load PC from pcnext
//   irwrite     load IR from readdata
//   regwrite    write register file (dest rt or rd, data aluout or data)
//   alusrca     ALU A operand: 0 PC, 1 A
//   iord        memory address: 0 PC, 1 aluout
//   memtoreg    register write data: 0 aluout, 1 data
//   regdst      register write address: 0 rt, 1 rd
//   alusrcb     ALU B operand: 00 B, 01 4, 10 signimm, 11 signimm<<2
//   pcsrc       next PC: 00 aluresult, 01 aluout, 10 jump target, 11 aluresult
//   alucontrol  010 add, 110 sub, 000 and, 001 or, 111 slt, others 0
//   readdata    memory read data for the current adr
//   op, funct   opcode and function fields of IR
//   zero        ALU result is zero
//   adr         memory address
//   writedata   store data (B)
module datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcen,
  input  logic        irwrite,
  input  logic        regwrite,
  input  logic        alusrca,
  input  logic        iord,
  input  logic        memtoreg,
  input  logic        regdst,
  input  logic [1:0]  alusrcb,
  input  logic [1:0]  pcsrc,
  input  logic [2:0]  alucontrol,
  input  logic [31:0] readdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] adr,
  output logic [31:0] writedata
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, a_q, b_q, aluout_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs, rt, rd, wa;
  logic [31:0] rd1, rd2, wd;
  logic [31:0] signimm, srca, srcb, aluresult, pcnext;

  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign rd = instr_q[15:11];

  // Register 0 is hardwired to zero on the read side; writes to it are
  // also dropped so the storage never holds anything but zero.
  assign rd1 = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign wa  = regdst ? rd : rt;
  assign wd  = memtoreg ? data_q : aluout_q;

  assign signimm = {{16{instr_q[15]}}, instr_q[15:0]};
  assign srca    = alusrca ? a_q : pc_q;

  always_comb begin
    srcb = b_q;
    case (alusrcb)
      2'b00:   srcb = b_q;
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = signimm;
      2'b11:   srcb = {signimm[29:0], 2'b00};
      default: srcb = b_q;
    endcase
  end

  always_comb begin
    aluresult = 32'd0;
    case (alucontrol)
      3'b010:  aluresult = srca + srcb;
      3'b110:  aluresult = srca - srcb;
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b111:  aluresult = {31'd0, ($signed(srca) < $signed(srcb))};
      default: aluresult = 32'd0;
    endcase
  end

  always_comb begin
    pcnext = aluresult;
    case (pcsrc)
      2'b00:   pcnext = aluresult;
      2'b01:   pcnext = aluout_q;
      2'b10:   pcnext = {pc_q[31:28], instr_q[25:0], 2'b00};
      default: pcnext = aluresult;
    endcase
  end

  assign pc_d    = pcen    ? pcnext   : pc_q;
  assign instr_d = irwrite ? readdata : instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      data_q   <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      data_q   <= readdata;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= aluresult;
    end
  end

  // Reads above are combinational from the pre-edge contents, so a read of
  // the register being written returns the old value this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (regwrite && (wa != 5'd0)) begin
      rf_q[wa] <= wd;
    end
  end

  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign zero      = (aluresult == 32'd0);
  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite),
    .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
    .op(op), .funct(funct), .zero(zero), .adr(adr), .writedata(writedata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0;
    iord = 0; memtoreg = 0; regdst = 0; alusrcb = 2'b00; pcsrc = 2'b00;
    alucontrol = 3'b000;
  endtask

  // Load IR, then one decode cycle so A/B hold the new rs/rt contents.
  task automatic load_ir(input logic [31:0] v);
    idle(); irwrite = 1; readdata = v;
    step();
    idle();
    step();
  endtask

  // addi rt, $0, imm : execute then writeback.
  task automatic write_imm(input logic [4:0] rt, input logic [15:0] imm);
    load_ir({6'h08, 5'd0, rt, imm});
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010;
    step();
    idle(); regwrite = 1;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; pcen = 1; regwrite = 1; irwrite = 1;
    readdata = 32'h2008_0005;
    step(); step();
    idle(); alucontrol = 3'b010;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL reset_pc: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if ({26'd0, op} !== e) begin bad++; $display("FAIL reset_op: got %h want %h", op, e); end
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL reset_b: got %h want %h", writedata, e); end
    iord = 1; #1;
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL reset_aluout: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if ({31'd0, zero} !== e) begin bad++; $display("FAIL reset_zero: got %h want %h", zero, e); end
    idle();
  endtask

  task automatic test_fetch();
    idle(); #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL fetch_adr0: got %h want %h", adr, e); end
    irwrite = 1; alusrcb = 2'b01; alucontrol = 3'b010; pcen = 1;
    readdata = 32'h2008_0005;
    exp_q.push_back(32'h4); exp_q.push_back(32'h08); exp_q.push_back(32'h05);
    step();
    idle();
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL fetch_pc: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if ({26'd0, op} !== e) begin bad++; $display("FAIL fetch_op: got %h want %h", op, e); end
    e = exp_q.pop_front(); total++;
    if ({26'd0, funct} !== e) begin bad++; $display("FAIL fetch_funct: got %h want %h", funct, e); end
  endtask

  task automatic test_addi();
    idle(); step();
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010; #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if ({31'd0, zero} !== e) begin bad++; $display("FAIL addi_zero: got %h want %h", zero, e); end
    step();
    idle(); regwrite = 1; iord = 1; #1;
    exp_q.push_back(32'h5);
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL addi_aluout: got %h want %h", adr, e); end
    step();
    idle();
    exp_q.push_back(32'h5);
    step();
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL addi_r8: got %h want %h", writedata, e); end
  endtask

  task automatic test_beq();
    write_imm(5'd9, 16'd5);
    idle(); irwrite = 1; pcen = 1; alusrcb = 2'b01; alucontrol = 3'b010;
    readdata = 32'h1109_0003;
    step();
    idle(); alusrcb = 2'b11; alucontrol = 3'b010;
    step();
    idle(); alusrca = 1; alucontrol = 3'b110; pcsrc = 2'b01; pcen = 1; iord = 1;
    exp_q.push_back(32'h1); exp_q.push_back(32'd20); exp_q.push_back(32'h5);
    exp_q.push_back(32'd20);
    #1;
    e = exp_q.pop_front(); total++;
    if ({31'd0, zero} !== e) begin bad++; $display("FAIL beq_zero: got %h want %h", zero, e); end
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL beq_target: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL beq_b: got %h want %h", writedata, e); end
    step();
    idle(); #1;
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL beq_pc: got %h want %h", adr, e); end
  endtask

  task automatic test_jump_pc();
    load_ir(32'h0810_0001);
    pcsrc = 2'b10; pcen = 1;
    exp_q.push_back(32'h0040_0004);
    step(); idle();
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL jump1_pc: got %h want %h", adr, e); end
    load_ir(32'h0810_0003);
    pcsrc = 2'b10; pcen = 1;
    exp_q.push_back(32'h0040_000C); exp_q.push_back(32'h02);
    step(); idle();
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL jump2_pc: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if ({26'd0, op} !== e) begin bad++; $display("FAIL jump_op: got %h want %h", op, e); end
    alusrcb = 2'b01; alucontrol = 3'b010; pcsrc = 2'b11; pcen = 1;
    exp_q.push_back(32'h0040_0010);
    step();
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL pcsrc11_pc: got %h want %h", adr, e); end
    pcen = 0; irwrite = 0; readdata = 32'hFC00_003F;
    exp_q.push_back(32'h0040_0010); exp_q.push_back(32'h02);
    step();
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL pc_hold: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if ({26'd0, op} !== e) begin bad++; $display("FAIL ir_hold: got %h want %h", op, e); end
    idle();
  endtask

  task automatic test_r0_hazard();
    load_ir(32'h2000_0007);
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010;
    step();
    idle(); regwrite = 1; iord = 1; #1;
    exp_q.push_back(32'h7);
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL r0_aluout: got %h want %h", adr, e); end
    step(); idle();
    exp_q.push_back(32'h0);
    step();
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL r0_read: got %h want %h", writedata, e); end
    load_ir(32'h2009_0009);
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010;
    step();
    idle(); regwrite = 1;
    exp_q.push_back(32'h5); exp_q.push_back(32'h9);
    step(); idle();
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL hazard_old: got %h want %h", writedata, e); end
    step();
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL hazard_new: got %h want %h", writedata, e); end
  endtask

  task automatic test_memtoreg();
    load_ir(32'h0000_5020);
    exp_q.push_back(32'h20);
    e = exp_q.pop_front(); total++;
    if ({26'd0, funct} !== e) begin bad++; $display("FAIL rtype_funct: got %h want %h", funct, e); end
    readdata = 32'h1234_5678;
    step();
    readdata = 32'h0; regwrite = 1; regdst = 1; memtoreg = 1;
    step(); idle();
    exp_q.push_back(32'h1234_5678);
    load_ir(32'h000A_0000);
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL memtoreg_r10: got %h want %h", writedata, e); end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ctl_t [8];
    logic [31:0] res_t [8];
    ctl_t[0] = 3'b010; res_t[0] = 32'h0000_0008;
    ctl_t[1] = 3'b110; res_t[1] = 32'hFFFF_FFF6;
    ctl_t[2] = 3'b000; res_t[2] = 32'h0000_0009;
    ctl_t[3] = 3'b001; res_t[3] = 32'hFFFF_FFFF;
    ctl_t[4] = 3'b111; res_t[4] = 32'h0000_0001;
    ctl_t[5] = 3'b011; res_t[5] = 32'h0000_0000;
    ctl_t[6] = 3'b100; res_t[6] = 32'h0000_0000;
    ctl_t[7] = 3'b101; res_t[7] = 32'h0000_0000;
    write_imm(5'd11, 16'hFFFF);
    load_ir(32'h0169_0000);
    for (int i = 0; i < 8; i++) begin
      idle(); alusrca = 1; iord = 1; alucontrol = ctl_t[i];
      exp_q.push_back({31'd0, (res_t[i] == 32'd0)});
      exp_q.push_back(res_t[i]);
      #1;
      e = exp_q.pop_front(); total++;
      if ({31'd0, zero} !== e) begin bad++; $display("FAIL alu_zero[%0d]: got %h want %h", i, zero, e); end
      step();
      e = exp_q.pop_front(); total++;
      if (adr !== e) begin bad++; $display("FAIL alu_res[%0d]: got %h want %h", i, adr, e); end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    idle(); reset = 1; pcen = 1; regwrite = 1; irwrite = 1; iord = 1;
    alusrcb = 2'b01; alucontrol = 3'b010; readdata = 32'hFFFF_FFFF;
    step();
    idle(); alucontrol = 3'b010;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL mreset_pc: got %h want %h", adr, e); end
    e = exp_q.pop_front(); total++;
    if ({26'd0, op} !== e) begin bad++; $display("FAIL mreset_op: got %h want %h", op, e); end
    e = exp_q.pop_front(); total++;
    if ({31'd0, zero} !== e) begin bad++; $display("FAIL mreset_zero: got %h want %h", zero, e); end
    iord = 1; #1;
    e = exp_q.pop_front(); total++;
    if (adr !== e) begin bad++; $display("FAIL mreset_aluout: got %h want %h", adr, e); end
    load_ir(32'h0008_0000);
    e = exp_q.pop_front(); total++;
    if (writedata !== e) begin bad++; $display("FAIL mreset_r8: got %h want %h", writedata, e); end
  endtask

  initial begin
    idle(); reset = 1; readdata = 32'h0;
    test_reset();
    test_fetch();
    test_addi();
    test_beq();
    test_jump_pc();
    test_r0_hazard();
    test_memtoreg();
    test_alu_ops();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
